// File: rtl/prog_sequencer.sv
// prog_sequencer: owns the processor instruction store and sequences bring-up.
//   A program is streamed in byte-wide while the processor is held in reset:
//   16-bit little-endian word count, then each word as lo byte, hi byte.
//   The processor is then released, instructions are fetched combinationally
//   from `pc`, and when `pc` runs past the loaded length the processor is put
//   back in reset and `done` is raised.
// Optional: define PROG_SEQ_CHECKSUM_EN to require a trailing XOR checksum
//   byte over all length and data bytes before the processor is released.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/in_ready/in_byte  loader byte stream (ready only while loading)
//   load_req        abort run / restart load (wins over everything but rst)
//   pc              processor program counter (PC_W bits)
//   instruction     fetched word, NOP_WORD when pc >= loaded_len
//   cpu_rst         registered processor reset
//   done            program ran past its end
//   err             length overflow (or checksum mismatch)
//   loaded_len      number of words stored (saturates at DEPTH)
module prog_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned PC_W     = 16,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              load_req,
  input  logic [PC_W-1:0]   pc,
  output logic [15:0]       instruction,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_len
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned CW      = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;
  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_LOAD_LEN0,
    S_LOAD_LEN1,
    S_LOAD_DATA,
    S_RUN,
    S_DONE,
    S_CHK
  } state_t;

`ifdef PROG_SEQ_CHECKSUM_EN
  localparam state_t LOAD_EXIT = S_CHK;
`else
  localparam state_t LOAD_EXIT = S_RUN;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic              hi_phase_q, hi_phase_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W:0]   loaded_len_q, loaded_len_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef PROG_SEQ_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic [15:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  logic              xfer;
  logic              in_range;
  logic [15:0]       len_full;

  assign in_range = CW'(pc) < CW'(loaded_len_q);
  assign len_full = {in_byte, len_q[7:0]};
  assign xfer     = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!load_req) begin
      unique case (state_q)
        S_LOAD_LEN0, S_LOAD_LEN1, S_LOAD_DATA: in_ready = 1'b1;
`ifdef PROG_SEQ_CHECKSUM_EN
        S_CHK:                                 in_ready = 1'b1;
`endif
        default:                               in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    widx_d       = widx_q;
    hi_phase_d   = hi_phase_q;
    lo_d         = lo_q;
    loaded_len_d = loaded_len_q;
    done_d       = done_q;
    err_d        = err_q;
`ifdef PROG_SEQ_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    // Registered from the current state so the processor leaves reset one
    // cycle after RUN is entered and re-enters it one cycle after leaving.
    cpu_rst_d    = (state_q != S_RUN);
    mem_we       = 1'b0;
    mem_waddr    = widx_q[ADDR_W-1:0];
    mem_wdata    = {in_byte, lo_q};

    if (load_req) begin
      state_d      = S_LOAD_LEN0;
      len_d        = '0;
      widx_d       = '0;
      hi_phase_d   = 1'b0;
      loaded_len_d = '0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      cpu_rst_d    = 1'b1;
`ifdef PROG_SEQ_CHECKSUM_EN
      chk_d        = '0;
`endif
    end else begin
`ifdef PROG_SEQ_CHECKSUM_EN
      if (xfer && state_q != S_CHK) chk_d = chk_q ^ in_byte;
`endif
      unique case (state_q)
        S_LOAD_LEN0: begin
          if (xfer) begin
            len_d[7:0] = in_byte;
            state_d    = S_LOAD_LEN1;
          end
        end
        S_LOAD_LEN1: begin
          if (xfer) begin
            len_d[15:8] = in_byte;
            if ({1'b0, len_full} > DEPTH17) begin
              err_d        = 1'b1;
              loaded_len_d = (ADDR_W + 1)'(DEPTH);
            end else begin
              loaded_len_d = (ADDR_W + 1)'(len_full);
            end
            state_d = (len_full == 16'd0) ? LOAD_EXIT : S_LOAD_DATA;
          end
        end
        S_LOAD_DATA: begin
          if (xfer) begin
            if (!hi_phase_q) begin
              lo_d       = in_byte;
              hi_phase_d = 1'b1;
            end else begin
              hi_phase_d = 1'b0;
              // Words beyond the memory are consumed but dropped.
              mem_we     = ({1'b0, widx_q} < DEPTH17);
              widx_d     = widx_q + 16'd1;
              if (widx_q + 16'd1 == len_q) state_d = LOAD_EXIT;
            end
          end
        end
        S_RUN: begin
          if (!cpu_rst_q && !in_range) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
`ifdef PROG_SEQ_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            if (in_byte == chk_q) begin
              state_d = S_RUN;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
`endif
        S_DONE:  state_d = S_DONE;
        default: state_d = S_LOAD_LEN0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD_LEN0;
      len_q        <= '0;
      widx_q       <= '0;
      hi_phase_q   <= 1'b0;
      lo_q         <= '0;
      loaded_len_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef PROG_SEQ_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      widx_q       <= widx_d;
      hi_phase_q   <= hi_phase_d;
      lo_q         <= lo_d;
      loaded_len_q <= loaded_len_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef PROG_SEQ_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  // Program store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instruction = in_range ? mem[pc[ADDR_W-1:0]] : NOP_WORD;
  assign cpu_rst     = cpu_rst_q;
  assign done        = done_q;
  assign err         = err_q;
  assign loaded_len  = loaded_len_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        load_req;
  logic [15:0] pc;

  logic        ready_a, cpu_rst_a, done_a, err_a;
  logic [15:0] instr_a;
  logic [8:0]  len_a;
  logic        ready_b, cpu_rst_b, done_b, err_b;
  logic [15:0] instr_b;
  logic [2:0]  len_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbuf [$];

  always #5 clk = ~clk;

  prog_sequencer #(.ADDR_W(8), .PC_W(16), .NOP_WORD(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .in_byte(in_byte), .load_req(load_req), .pc(pc), .instruction(instr_a),
    .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a), .loaded_len(len_a)
  );

  prog_sequencer #(.ADDR_W(2), .PC_W(16), .NOP_WORD(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .in_byte(in_byte), .load_req(load_req), .pc(pc), .instruction(instr_b),
    .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b), .loaded_len(len_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    #1;
    check_eq("in_ready_a", 32'(ready_a), 32'd1);
    check_eq("in_ready_b", 32'(ready_b), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream();
    logic [7:0] x;
    x = 8'h00;
    foreach (sbuf[i]) begin
      send_byte(sbuf[i]);
      x = x ^ sbuf[i];
    end
`ifdef PROG_SEQ_CHECKSUM_EN
    send_byte(x);
`endif
    sbuf.delete();
  endtask

  task automatic restart();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    check_eq("restart_done", 32'(done_a), 32'd0);
    check_eq("restart_len", 32'(len_a), 32'd0);
    check_eq("restart_err", 32'(err_b), 32'd0);
    check_eq("restart_cpu_rst", 32'(cpu_rst_a), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    load_req = 1'b0;
    pc       = 16'd0;

    // Reset values
    #12;
    check_eq("rst_cpu_rst", 32'(cpu_rst_a), 32'd1);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    check_eq("rst_len", 32'(len_a), 32'd0);
    check_eq("rst_ready", 32'(ready_a), 32'd1);
    check_eq("rst_instr_nop", 32'(instr_a), 32'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Two-word program
    sbuf = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    send_stream();
    check_eq("p2_cpu_rst_held", 32'(cpu_rst_a), 32'd1);
    check_eq("p2_ready_low", 32'(ready_a), 32'd0);
    check_eq("p2_len_a", 32'(len_a), 32'd2);
    check_eq("p2_len_b", 32'(len_b), 32'd2);
    check_eq("p2_instr0_a", 32'(instr_a), 32'h1234);
    check_eq("p2_instr0_b", 32'(instr_b), 32'h1234);
    tick(1);
    check_eq("p2_cpu_rst_fall_a", 32'(cpu_rst_a), 32'd0);
    check_eq("p2_cpu_rst_fall_b", 32'(cpu_rst_b), 32'd0);
    pc = 16'd1;
    #1;
    check_eq("p2_instr1", 32'(instr_a), 32'h5678);
    tick(1);
    check_eq("p2_done_early", 32'(done_a), 32'd0);
    pc = 16'd2;
    #1;
    check_eq("p2_instr2_nop", 32'(instr_a), 32'h0000);
    tick(1);
    check_eq("p2_done_a", 32'(done_a), 32'd1);
    check_eq("p2_done_b", 32'(done_b), 32'd1);
    check_eq("p2_cpu_rst_still_low", 32'(cpu_rst_a), 32'd0);
    tick(1);
    check_eq("p2_cpu_rst_rearm", 32'(cpu_rst_a), 32'd1);
    check_eq("p2_done_sticky", 32'(done_a), 32'd1);

    // Zero-length program
    restart();
    pc = 16'd0;
    sbuf = '{8'h00, 8'h00};
    send_stream();
    check_eq("z_cpu_rst_held", 32'(cpu_rst_a), 32'd1);
    check_eq("z_instr_nop", 32'(instr_a), 32'h0000);
    tick(1);
    check_eq("z_cpu_rst_fall", 32'(cpu_rst_a), 32'd0);
    check_eq("z_done_not_yet", 32'(done_a), 32'd0);
    tick(1);
    check_eq("z_done", 32'(done_a), 32'd1);

    // Length 5: overflows the ADDR_W=2 instance only
    restart();
    sbuf = '{8'h05, 8'h00, 8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2,
             8'hA3, 8'hB3, 8'hA4, 8'hB4};
    send_stream();
    check_eq("ov_err_a", 32'(err_a), 32'd0);
    check_eq("ov_err_b", 32'(err_b), 32'd1);
    check_eq("ov_len_a", 32'(len_a), 32'd5);
    check_eq("ov_len_b", 32'(len_b), 32'd4);
    check_eq("ov_ready_b_low", 32'(ready_b), 32'd0);
    check_eq("ov_word0_b_kept", 32'(instr_b), 32'hB0A0);
    check_eq("ov_word0_a", 32'(instr_a), 32'hB0A0);
    pc = 16'd3;
    #1;
    check_eq("ov_word3_b", 32'(instr_b), 32'hB3A3);
    pc = 16'd4;
    #1;
    check_eq("ov_word4_a", 32'(instr_a), 32'hB4A4);
    check_eq("ov_word4_b_nop", 32'(instr_b), 32'h0000);
    pc = 16'd5;
    #1;
    check_eq("ov_word5_a_nop", 32'(instr_a), 32'h0000);
    tick(1);
    check_eq("ov_cpu_rst_fall_b", 32'(cpu_rst_b), 32'd0);

    // load_req mid LOAD_DATA with a byte offered
    restart();
    pc = 16'd0;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h77);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h88;
    load_req = 1'b1;
    #1;
    check_eq("lr_ready_forced_low", 32'(ready_a), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lr_len", 32'(len_a), 32'd0);
    load_req = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("lr_ready_len0", 32'(ready_a), 32'd1);
    check_eq("lr_cpu_rst", 32'(cpu_rst_a), 32'd1);
    sbuf = '{8'h01, 8'h00, 8'hCD, 8'hAB};
    send_stream();
    check_eq("lr_reload_len", 32'(len_a), 32'd1);
    check_eq("lr_reload_instr", 32'(instr_a), 32'hABCD);
    tick(1);
    check_eq("lr_run_cpu_rst", 32'(cpu_rst_a), 32'd0);

    // Asynchronous reset while running
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_cpu_rst", 32'(cpu_rst_a), 32'd1);
    check_eq("arst_done", 32'(done_a), 32'd0);
    check_eq("arst_len", 32'(len_a), 32'd0);
    check_eq("arst_instr_nop", 32'(instr_a), 32'h0000);
    @(negedge clk);
    rst = 1'b0;

`ifdef PROG_SEQ_CHECKSUM_EN
    // Good and bad checksum
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'hFE);
    tick(1);
    check_eq("ck_good_cpu_rst", 32'(cpu_rst_a), 32'd0);
    check_eq("ck_good_err", 32'(err_a), 32'd0);
    restart();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'hFF);
    check_eq("ck_bad_err", 32'(err_a), 32'd1);
    tick(3);
    check_eq("ck_bad_cpu_rst", 32'(cpu_rst_a), 32'd1);
    check_eq("ck_bad_done", 32'(done_a), 32'd0);
    check_eq("ck_bad_ready", 32'(ready_a), 32'd0);
    check_eq("ck_bad_err_hold", 32'(err_a), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
